// File: rtl/core_sel_ctrl_pkg.sv
// Shared definitions for the core-select sequencer: FSM encoding, default
// parameter values and a counter-width helper.
package core_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_RESET_HOLD    = 8;
  localparam int DEF_DRAIN_TIMEOUT = 256;
  localparam int DEF_CNT_W         = 8;

  // A counter that runs 0..n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_sel_ctrl_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level input.
// All stages clear to 0 under the synchronous active-low reset.
module core_sel_ctrl_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/core_sel_ctrl.sv
// Safe core-switch sequencer: qualifies the chip-select pin, drains the bus,
// holds both cores in reset for a fixed window and releases the new one.
module core_sel_ctrl
  import core_sel_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RESET_HOLD    = DEF_RESET_HOLD,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_sel_i,
  input  logic             m0_req_i,
  input  logic             rib_hold_flag_i,
  output logic             chip_sel_o,
  output logic             core0_rst_o,
  output logic             core1_rst_o,
  output logic             switching_o,
  output logic             drain_timeout_o,
  output logic [CNT_W-1:0] switch_cnt_o
);

  localparam int HOLD_W   = cnt_width(RESET_HOLD);
  localparam int STABLE_W = cnt_width(STABLE_CYCLES);
  localparam int DRAIN_W  = cnt_width(DRAIN_TIMEOUT);

  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);

  logic sel_sync;

  core_sel_ctrl_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sel_sync (
    .clk (clk),
    .rst (rst),
    .d_i (chip_sel_i),
    .q_o (sel_sync)
  );

  state_e              state_q,         state_d;
  logic                post_reset_q,    post_reset_d;
  logic [HOLD_W-1:0]   hold_cnt_q,      hold_cnt_d;
  logic [STABLE_W-1:0] stable_cnt_q,    stable_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q,     drain_cnt_d;
  logic                chip_sel_q,      chip_sel_d;
  logic                core0_rst_q,     core0_rst_d;
  logic                core1_rst_q,     core1_rst_d;
  logic                switching_q,     switching_d;
  logic                drain_timeout_q, drain_timeout_d;
  logic [CNT_W-1:0]    switch_cnt_q,    switch_cnt_d;

  logic mismatch;
  logic bus_idle;

  assign mismatch = (sel_sync != chip_sel_q);
  assign bus_idle = !m0_req_i && !rib_hold_flag_i;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    state_d         = state_q;
    post_reset_d    = post_reset_q;
    hold_cnt_d      = hold_cnt_q;
    stable_cnt_d    = '0;
    drain_cnt_d     = drain_cnt_q;
    chip_sel_d      = chip_sel_q;
    core0_rst_d     = core0_rst_q;
    core1_rst_d     = core1_rst_q;
    drain_timeout_d = drain_timeout_q;
    switch_cnt_d    = switch_cnt_q;

    case (state_q)
      ST_HOLD: begin
        core0_rst_d = 1'b0;
        core1_rst_d = 1'b0;
        // After reset the selection tracks the pin; after a switch it is locked.
        if (post_reset_q) begin
          chip_sel_d = sel_sync;
        end
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          hold_cnt_d   = '0;
          post_reset_d = 1'b0;
          core0_rst_d  = !chip_sel_d;
          core1_rst_d  = chip_sel_d;
          if (!post_reset_q && (switch_cnt_q != '1)) begin
            switch_cnt_d = switch_cnt_q + 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (mismatch) begin
          if (stable_cnt_q == STABLE_LAST) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // A reverted pin wins over both an idle bus and an expiring timeout.
        if (!mismatch) begin
          state_d = ST_RUN;
        end else if (bus_idle || (drain_cnt_q == DRAIN_LAST)) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          drain_cnt_d = '0;
          chip_sel_d  = !chip_sel_q;
          core0_rst_d = 1'b0;
          core1_rst_d = 1'b0;
          if (!bus_idle) begin
            drain_timeout_d = 1'b1;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d      = ST_HOLD;
        post_reset_d = 1'b1;
        hold_cnt_d   = '0;
        core0_rst_d  = 1'b0;
        core1_rst_d  = 1'b0;
      end
    endcase

    switching_d = (state_d != ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_HOLD;
      post_reset_q    <= 1'b1;
      hold_cnt_q      <= '0;
      stable_cnt_q    <= '0;
      drain_cnt_q     <= '0;
      chip_sel_q      <= 1'b0;
      core0_rst_q     <= 1'b0;
      core1_rst_q     <= 1'b0;
      switching_q     <= 1'b1;
      drain_timeout_q <= 1'b0;
      switch_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      post_reset_q    <= post_reset_d;
      hold_cnt_q      <= hold_cnt_d;
      stable_cnt_q    <= stable_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      chip_sel_q      <= chip_sel_d;
      core0_rst_q     <= core0_rst_d;
      core1_rst_q     <= core1_rst_d;
      switching_q     <= switching_d;
      drain_timeout_q <= drain_timeout_d;
      switch_cnt_q    <= switch_cnt_d;
    end
  end

  assign chip_sel_o      = chip_sel_q;
  assign core0_rst_o     = core0_rst_q;
  assign core1_rst_o     = core1_rst_q;
  assign switching_o     = switching_q;
  assign drain_timeout_o = drain_timeout_q;
  assign switch_cnt_o    = switch_cnt_q;

endmodule

// File: tb/tb_core_sel_ctrl.sv
// Self-checking bench for core_sel_ctrl: directed vector table, hand-written
// timeout and saturation sequences, then random traffic against a model.
module tb_core_sel_ctrl;
  import core_sel_ctrl_pkg::*;

  localparam int SYNC   = DEF_SYNC_STAGES;
  localparam int STABLE = DEF_STABLE_CYCLES;
  localparam int HOLD   = DEF_RESET_HOLD;
  localparam int DRAIN  = DEF_DRAIN_TIMEOUT;
  localparam int CW     = DEF_CNT_W;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int RAND_CYCLES = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic          chip_sel_i;
  logic          m0_req_i;
  logic          rib_hold_flag_i;
  logic          chip_sel_o;
  logic          core0_rst_o;
  logic          core1_rst_o;
  logic          switching_o;
  logic          drain_timeout_o;
  logic [CW-1:0] switch_cnt_o;

  core_sel_ctrl #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .RESET_HOLD    (HOLD),
    .DRAIN_TIMEOUT (DRAIN),
    .CNT_W         (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .chip_sel_i      (chip_sel_i),
    .m0_req_i        (m0_req_i),
    .rib_hold_flag_i (rib_hold_flag_i),
    .chip_sel_o      (chip_sel_o),
    .core0_rst_o     (core0_rst_o),
    .core1_rst_o     (core1_rst_o),
    .switching_o     (switching_o),
    .drain_timeout_o (drain_timeout_o),
    .switch_cnt_o    (switch_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Packed view {sel, core0_rst, core1_rst, switching, timeout, count}.
  function automatic logic [CW+4:0] dut_out();
    return {chip_sel_o, core0_rst_o, core1_rst_o, switching_o, drain_timeout_o, switch_cnt_o};
  endfunction

  function automatic logic [CW+4:0] pack(input logic sel, input logic c0, input logic c1,
                                         input logic sw, input logic to, input int cnt);
    return {sel, c0, c1, sw, to, CW'(cnt)};
  endfunction

  task automatic check(input string name, input logic [CW+4:0] act, input logic [CW+4:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got sel/c0/c1/sw/to=%b cnt=%0d, want sel/c0/c1/sw/to=%b cnt=%0d",
               name, $time, act[CW+4:CW], act[CW-1:0], exp[CW+4:CW], exp[CW-1:0]);
    end
  endtask

  // Apply the current inputs for n clock edges, landing on a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_pipe[$];
  int m_hold_left, m_mis_run, m_drain_age;
  bit m_in_drain, m_post;
  bit m_sel, m_c0, m_c1, m_sw, m_to;
  int m_cnt;

  // Predicts the outputs after the next rising edge given the current inputs.
  task automatic model_step();
    int cur;
    bit busy;
    if (!rst) begin
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(0);
      m_hold_left = HOLD; m_post = 1; m_in_drain = 0; m_mis_run = 0; m_drain_age = 0;
      m_sel = 0; m_c0 = 0; m_c1 = 0; m_sw = 1; m_to = 0; m_cnt = 0;
      return;
    end
    cur = m_pipe.pop_front();
    m_pipe.push_back(int'(chip_sel_i));
    busy = m0_req_i || rib_hold_flag_i;
    if (m_hold_left > 0) begin
      if (m_post) m_sel = cur[0];
      m_hold_left--;
      if (m_hold_left == 0) begin
        if (!m_post && m_cnt < CNT_MAX) m_cnt++;
        m_post = 0; m_sw = 0; m_c0 = !m_sel; m_c1 = m_sel; m_mis_run = 0;
      end
    end else if (!m_in_drain) begin
      if (cur[0] != m_sel) begin
        m_mis_run++;
        if (m_mis_run == STABLE) begin
          m_in_drain = 1; m_drain_age = 0; m_sw = 1; m_mis_run = 0;
        end
      end else begin
        m_mis_run = 0;
      end
    end else if (cur[0] == m_sel) begin
      m_in_drain = 0; m_sw = 0;
    end else begin
      m_drain_age++;
      if (!busy || m_drain_age == DRAIN) begin
        if (busy) m_to = 1;
        m_in_drain = 0; m_hold_left = HOLD; m_sel = !m_sel; m_c0 = 0; m_c1 = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string name;
    logic  rst, pin, req, hld;
    int    n;
    logic  sel, c0, c1, sw, to;
    int    cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic p, input logic q, input logic h,
                     input int n, input logic sel, input logic c0, input logic c1,
                     input logic sw, input logic to, input int cnt);
    vec_t v;
    v.name = name; v.rst = r; v.pin = p; v.req = q; v.hld = h; v.n = n;
    v.sel = sel; v.c0 = c0; v.c1 = c1; v.sw = sw; v.to = to; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pin;
    int bus_mode;
    rst = 1'b0; chip_sel_i = 1'b1; m0_req_i = 1'b0; rib_hold_flag_i = 1'b0;

    //   name               rst pin req hld  n   sel c0 c1 sw to cnt
    add("reset",            0,  1,  0,  0,   3,  0,  0, 0, 1, 0, 0);
    add("post_hold",        1,  1,  0,  0,   7,  1,  0, 0, 1, 0, 0);
    add("post_release",     1,  1,  0,  0,   1,  1,  0, 1, 0, 0, 0);
    add("pre_drain",        1,  0,  0,  0,  17,  1,  0, 1, 0, 0, 0);
    add("drain_entry",      1,  0,  0,  0,   1,  1,  0, 1, 1, 0, 0);
    add("idle_to_hold",     1,  0,  0,  0,   1,  0,  0, 0, 1, 0, 0);
    add("hold_window",      1,  0,  0,  0,   7,  0,  0, 0, 1, 0, 0);
    add("release_core0",    1,  0,  0,  0,   1,  0,  1, 0, 0, 0, 1);
    add("glitch_high",      1,  1,  0,  0,  10,  0,  1, 0, 0, 0, 1);
    add("glitch_settle",    1,  0,  0,  0,  20,  0,  1, 0, 0, 0, 1);
    add("busy_pre_drain",   1,  1,  1,  0,  17,  0,  1, 0, 0, 0, 1);
    add("busy_drain_entry", 1,  1,  1,  0,   1,  0,  1, 0, 1, 0, 1);
    add("busy_40",          1,  1,  1,  0,  40,  0,  1, 0, 1, 0, 1);
    add("hold_flag_busy",   1,  1,  0,  1,   5,  0,  1, 0, 1, 0, 1);
    add("busy_then_idle",   1,  1,  0,  0,   1,  1,  0, 0, 1, 0, 1);
    add("release_core1",    1,  1,  0,  0,   8,  1,  0, 1, 0, 0, 2);
    add("revert_drain",     1,  0,  1,  0,  18,  1,  0, 1, 1, 0, 2);
    add("revert_pending",   1,  1,  1,  0,   2,  1,  0, 1, 1, 0, 2);
    add("revert_run",       1,  1,  0,  0,   1,  1,  0, 1, 0, 0, 2);
    add("revert_stays",     1,  1,  0,  0,  20,  1,  0, 1, 0, 0, 2);
    add("mid_reset",        0,  1,  0,  0,   1,  0,  0, 0, 1, 0, 0);
    add("reset_release0",   1,  0,  0,  0,   8,  0,  1, 0, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; chip_sel_i = vecs[i].pin;
      m0_req_i = vecs[i].req; rib_hold_flag_i = vecs[i].hld;
      cycles(vecs[i].n);
      check(vecs[i].name, dut_out(),
            pack(vecs[i].sel, vecs[i].c0, vecs[i].c1, vecs[i].sw, vecs[i].to, vecs[i].cnt));
    end

    // Stuck bus: DRAIN lasts exactly DRAIN_TIMEOUT cycles, then the flag sticks until reset.
    chip_sel_i = 1'b1; m0_req_i = 1'b1;
    cycles(SYNC + STABLE); check("to_drain_entry",  dut_out(), pack(0, 1, 0, 1, 0, 0));
    cycles(DRAIN - 1);     check("to_before_limit", dut_out(), pack(0, 1, 0, 1, 0, 0));
    cycles(1);             check("to_forced_hold",  dut_out(), pack(1, 0, 0, 1, 1, 0));
    cycles(HOLD);          check("to_release",      dut_out(), pack(1, 0, 1, 0, 1, 1));
    m0_req_i = 1'b0;
    cycles(30);            check("to_sticky",       dut_out(), pack(1, 0, 1, 0, 1, 1));
    chip_sel_i = 1'b0;
    cycles(27);            check("to_sticky_switch", dut_out(), pack(0, 1, 0, 0, 1, 2));
    rst = 1'b0;
    cycles(1);             check("to_cleared",      dut_out(), pack(0, 0, 0, 1, 0, 0));
    rst = 1'b1;
    cycles(HOLD);          check("sat_start",       dut_out(), pack(0, 1, 0, 0, 0, 0));

    // Saturation: idle-bus switches every 27 cycles, count clamps at all-ones.
    pin = 1'b0;
    for (int i = 0; i < 260; i++) begin
      pin = ~pin;
      chip_sel_i = pin;
      cycles(27);
      check("saturate", dut_out(), pack(pin, !pin, pin, 0, 0, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
    end

    // Random traffic against the reference model, starting from a reset.
    bus_mode = 0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if (c % 300 == 0) bus_mode = int'($urandom_range(0, 2));
      rst = (c == 0) ? 1'b0 : ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, (bus_mode == 2) ? 299 : 29) == 0) chip_sel_i = ~chip_sel_i;
      case (bus_mode)
        0: begin
          m0_req_i = ($urandom_range(0, 3) == 0);
          rib_hold_flag_i = ($urandom_range(0, 3) == 0);
        end
        1: begin
          m0_req_i = ($urandom_range(0, 9) != 0);
          rib_hold_flag_i = 1'($urandom_range(0, 1));
        end
        default: begin
          m0_req_i = 1'b1;
          rib_hold_flag_i = 1'b0;
        end
      endcase
      model_step();
      @(negedge clk);
      check("random", dut_out(), pack(m_sel, m_c0, m_c1, m_sw, m_to, m_cnt));
      if (core0_rst_o && core1_rst_o) begin
        check("both_released", 1'b0, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_sel_ctrl.md
# core_sel_ctrl

Safe core-switch sequencer for the dual-core SoC. It synchronises and qualifies the raw chip-select pin, then drains the shared data bus before any switch, so the active core never changes while a bus transfer is in flight. It holds both cores in reset for a fixed window, then releases only the newly selected one. Its outputs drive the SoC top's master-0/master-1 and JTAG muxes and the two per-core resets.

## Interface
- SYNC_STAGES, 2, flops in chip-select synchroniser (≥2)
- STABLE_CYCLES, 16, consecutive mismatch cycles required to accept a new selection
- RESET_HOLD, 8, cycles both cores are held in reset per switch and after reset
- DRAIN_TIMEOUT, 256, max cycles waited in DRAIN before forcing the switch
- CNT_W, 8, switch counter width
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- chip_sel_i  in  1  raw chip-select pin, asynchronous (0 = core 2023211063, 1 = core yw)
- m0_req_i  in  1  data-bus request from the currently selected core
- rib_hold_flag_i  in  1  bus-arbiter hold flag
- chip_sel_o  out  1  registered selection to the SoC muxes
- core0_rst_o  out  1  core 0 reset, active-low
- core1_rst_o  out  1  core 1 reset, active-low
- switching_o  out  1  high in DRAIN and HOLD
- drain_timeout_o  out  1  sticky; a drain timed out
- switch_cnt_o  out  CNT_W  completed switches, saturating

## Operation
- sel_sync: output of the SYNC_STAGES-flop chain on chip_sel_i. The chain resets to 0.
- States: HOLD, RUN, DRAIN.
- Reset (rst=0):
  - State: HOLD, with the post-reset flag set.
  - Counters: all 0.
  - Outputs: chip_sel_o=0, core0_rst_o=0, core1_rst_o=0, switching_o=1, drain_timeout_o=0, switch_cnt_o=0.
- HOLD:
  - Both resets are 0 and switching_o=1.
  - The hold counter runs 0..RESET_HOLD-1.
  - In post-reset HOLD, chip_sel_o <= sel_sync every cycle.
  - In switch HOLD, chip_sel_o is loaded on entry and then locked.
  - On the last count:
    - Next state is RUN.
    - The reset of the selected core goes to 1.
    - switching_o goes to 0.
    - switch_cnt_o increments (saturating at all-ones), but only if this was not the post-reset HOLD.
    - The post-reset flag clears.
- RUN:
  - The stable counter increments while sel_sync != chip_sel_o and clears to 0 on equality.
  - When it reaches STABLE_CYCLES-1 with a mismatch, the next state is DRAIN.
- DRAIN:
  - switching_o=1. The selected core keeps running.
  - If sel_sync == chip_sel_o, the next state is RUN with no switch and no count.
  - Else if m0_req_i=0 and rib_hold_flag_i=0 in the same cycle, the next state is HOLD and chip_sel_o <= ~chip_sel_o.
  - Else the drain counter increments. At DRAIN_TIMEOUT-1 the block forces HOLD as above and sets drain_timeout_o.
- Revert priority in DRAIN: revert beats both idle and timeout when they occur in the same cycle.
- Clearing drain_timeout_o: only rst clears it.
- Reset during any state: the block returns to post-reset HOLD on the next edge, and both cores go into reset.

## Timing
- Pin change to DRAIN entry: SYNC_STAGES + STABLE_CYCLES cycles (18 at defaults).
- DRAIN to HOLD: 1 cycle after the first idle cycle.
- HOLD lasts exactly RESET_HOLD cycles.
- Idle bus: pin change to new core reset release = 18 + 1 + 8 = 27 cycles.
- Reset release to first core release: RESET_HOLD cycles.
- All outputs are registered. There is no combinational path from input to output.
- The two core resets are never 1 simultaneously.
- The reset of the deselected core goes to 0 in the same cycle chip_sel_o changes.

## Structure
- Shared package holds:
  - the state encoding (HOLD=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the default parameter constants.
- One sub-module: sync_chain (parameterised depth, synchronous active-low reset to 0), instantiated once for chip_sel_i.
- Counters are sized with $clog2 of their parameter.
- The block resides beside the SoC top.
- Once the block is integrated:
  - the SoC top's core reset gating uses core0_rst_o/core1_rst_o;
  - the SoC top's muxes use chip_sel_o.

## Test plan
- Post-reset: chip_sel_i=1 held, rst released → after 8 cycles chip_sel_o=1, core1_rst_o=1, core0_rst_o=0, switch_cnt_o=0.
- Glitch: chip_sel_i toggles high for 10 cycles while in RUN on core 0 → no DRAIN, no output change, stable counter cleared.
- Clean switch 0→1 with idle bus → DRAIN entered 18 cycles after the pin edge. Then:
  - both resets are 0 for 8 cycles;
  - core1_rst_o=1 at cycle 27;
  - switch_cnt_o=1.
- Busy bus: m0_req_i=1 for 40 cycles in DRAIN, then 0 → HOLD next cycle, drain_timeout_o stays 0.
- Stuck bus: m0_req_i=1 permanently → HOLD forced after 256 DRAIN cycles, drain_timeout_o=1 until rst.
- Revert in DRAIN and saturation:
  - Revert: pin returns to 0 during DRAIN → RUN, no count, core0 never reset.
  - Saturation: 260 switches → switch_cnt_o=255.
